// File: rtl/mio_pkg.sv
// mio_pkg: shared constants, state encoding and region type for the MIO responder
package mio_pkg;
  localparam logic [3:0] IO_BASE_NIB = 4'hF;
  localparam logic [1:0] IO_GPIO = 2'd0;
  localparam logic [1:0] IO_CNT = 2'd1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_e;
  typedef enum logic {REG_RAM, REG_IO} region_e;
endpackage

// File: rtl/mio_counter.sv
// mio_counter: 32-bit free-running wrapping counter, load wins over increment
//   clk, rst_n : clock, async active-low reset
//   ld, d      : load strobe and load value
//   q          : counter value
module mio_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= ld ? d : q + 32'd1;
endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: MIO-port responder with RAM wait states, GPIO LEDs and counter
//   clk, rst_n              : clock, async active-low reset
//   mem_req, mem_w          : access request (sampled in IDLE) and write flag
//   M_addr, data_out        : CPU byte address and write data
//   data2CPU, MIO_ready     : read data (held between ACKs) and CPU pacing
//   ram_addr/ram_din/ram_we : registered synchronous-RAM request
//   ram_dout                : RAM read data, RAM_LAT cycles after ram_addr
//   sw, led                 : switch inputs and GPIO LED register
import mio_pkg::*;
module mio_bus_responder #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_w,
  input  logic [31:0]       M_addr,
  input  logic [31:0]       data_out,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [SW_W-1:0]   sw,
  output logic [SW_W-1:0]   led
);
  localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);
  state_e state_q, state_d;
  region_e reg_q, region_d;
  logic [2:0] cnt_q, cnt_d;
  logic we_q, ram_we_q, start, fin, io_wr, unused_addr;
  logic [1:0] off_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [SW_W-1:0] led_q;
  logic [31:0] ram_din_q, rd_q, d2c_q, cnt_val, io_rd;
  assign unused_addr = ^{M_addr[27:RAM_AW+2], M_addr[1:0]};
  // Every access passes through WAIT so the CPU always sees at least one stall;
  // RAM reads stay there RAM_LAT cycles so ram_dout is valid during ACK.
  always_comb begin
    region_d = (M_addr[31:28] == IO_BASE_NIB) ? REG_IO : REG_RAM;
    start = (state_q == IDLE) && mem_req;
    fin = (state_q == WAIT) && (cnt_q == 3'd0);
    io_wr = fin && we_q && (reg_q == REG_IO);
    state_d = start ? WAIT : fin ? ACK : (state_q == ACK) ? IDLE : state_q;
    cnt_d = start ? ((!mem_w && region_d == REG_RAM) ? LAT_M1 : 3'd0)
          : (state_q == WAIT && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    io_rd = (off_q == IO_GPIO) ? 32'(sw) : (off_q == IO_CNT) ? cnt_val : 32'h0;
    data2CPU = (state_q == ACK && !we_q) ? ((reg_q == REG_RAM) ? ram_dout : rd_q) : d2c_q;
  end
  mio_counter u_cnt (
    .clk(clk), .rst_n(rst_n), .ld(io_wr && off_q == IO_CNT), .d(ram_din_q), .q(cnt_val)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      reg_q <= REG_RAM;
      we_q <= 1'b0;
      off_q <= '0;
      ram_addr_q <= '0;
      ram_din_q <= '0;
      ram_we_q <= 1'b0;
      led_q <= '0;
      rd_q <= '0;
      d2c_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ram_we_q <= start && mem_w && (region_d == REG_RAM);
      d2c_q <= data2CPU;
      if (start) begin
        we_q <= mem_w;
        reg_q <= region_d;
        off_q <= M_addr[3:2];
        ram_addr_q <= M_addr[RAM_AW+1:2];
        ram_din_q <= data_out;
      end
      // IO read data (including the counter snapshot) is taken at the edge entering ACK.
      if (fin) rd_q <= io_rd;
      if (io_wr && off_q == IO_GPIO) led_q <= ram_din_q[SW_W-1:0];
    end
  assign MIO_ready = (state_q != WAIT);
  assign ram_addr = ram_addr_q;
  assign ram_din = ram_din_q;
  assign ram_we = ram_we_q;
  assign led = led_q;
endmodule
